// File: rtl/mul_exec_unit.sv
// Execute-stage multiply unit: two-stage valid/ready pipeline around a
// combinational 32x32 multiply core, returning the selected product word with its tag.

module mult_core (
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    input  logic        sign_en,
    output logic [63:0] prod
);
    logic [63:0] a_ext;
    logic [63:0] b_ext;

    // Sign- or zero-extend to 64 bits; the low 64 bits of the product are then exact
    always_comb begin
        a_ext = {{32{sign_en & op1[31]}}, op1};
        b_ext = {{32{sign_en & op2[31]}}, op2};
        prod  = a_ext * b_ext;
    end
endmodule

module mul_exec_unit #(
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [31:0]      in_src1,
    input  logic [31:0]      in_src2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);
    localparam int unsigned DATA_W = 32;
    localparam logic [1:0]  OP_MULH  = 2'b01;
    localparam logic [1:0]  OP_MULHU = 2'b10;

    logic              s1_valid;
    logic [DATA_W-1:0] s1_src1;
    logic [DATA_W-1:0] s1_src2;
    logic [1:0]        s1_op;
    logic [TAG_W-1:0]  s1_tag;
    logic              s2_valid;

    logic              s2_adv;
    logic              s1_adv;
    logic              in_fire;
    logic              out_fire;
    logic              sign_en;
    logic              sel_hi;
    logic [2*DATA_W-1:0] prod;

    // Handshake and advance terms; in_ready looks through to out_ready
    assign s2_adv    = !s2_valid | out_ready;
    assign s1_adv    = s1_valid & s2_adv;
    assign in_ready  = !flush & (!s1_valid | s2_adv);
    assign in_fire   = in_valid & in_ready;
    assign out_valid = s2_valid & !flush;
    assign out_fire  = out_valid & out_ready;
    assign busy      = s1_valid | s2_valid;

    assign sign_en = (s1_op == OP_MULH);
    assign sel_hi  = (s1_op == OP_MULH) | (s1_op == OP_MULHU);

    mult_core multCore (
        .op1     (s1_src1),
        .op2     (s1_src2),
        .sign_en (sign_en),
        .prod    (prod)
    );

    // Stage 1: operand capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_src1  <= '0;
            s1_src2  <= '0;
            s1_op    <= '0;
            s1_tag   <= '0;
        end else begin
            if (flush)        s1_valid <= 1'b0;
            else if (in_fire) s1_valid <= 1'b1;
            else if (s1_adv)  s1_valid <= 1'b0;

            if (in_fire) begin
                s1_src1 <= in_src1;
                s1_src2 <= in_src2;
                s1_op   <= in_op;
                s1_tag  <= in_tag;
            end
        end
    end

    // Stage 2: result word select and hold under backpressure
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid   <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
        end else begin
            if (flush)         s2_valid <= 1'b0;
            else if (s1_adv)   s2_valid <= 1'b1;
            else if (out_fire) s2_valid <= 1'b0;

            if (s1_adv) begin
                out_result <= sel_hi ? prod[2*DATA_W-1:DATA_W] : prod[DATA_W-1:0];
                out_tag    <= s1_tag;
            end
        end
    end
endmodule

// File: tb/tb_mul_exec_unit.sv
// Self-checking bench for mul_exec_unit: directed corners plus randomized traffic
// scored against an in-order queue model of in-flight ops.

module tb_mul_exec_unit;
    localparam int unsigned TAG_W = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [31:0]      in_src1;
    logic [31:0]      in_src2;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_result;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    logic [31:0]      exp_drv;

    int tests = 0;
    int fails = 0;
    int n_acc = 0;

    typedef struct {
        logic [31:0]      res;
        logic [TAG_W-1:0] tag;
        int               age;
    } ent_t;
    ent_t q[$];

    mul_exec_unit #(.TAG_W(TAG_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_src1    (in_src1),
        .in_src2    (in_src2),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sp;
        longint unsigned up;
        sp = longint'($signed(a)) * longint'($signed(b));
        up = {32'b0, a} * {32'b0, b};
        case (op)
            2'b01:   return sp[63:32];
            2'b10:   return up[63:32];
            default: return up[31:0];
        endcase
    endfunction

    // Monitor: sampled mid-cycle, inputs and outputs are stable until the next rising edge
    logic             prev_hold = 1'b0;
    logic [31:0]      prev_res;
    logic [TAG_W-1:0] prev_tag;
    always @(negedge clk) begin
        if (reset) begin
            q.delete();
            prev_hold = 1'b0;
        end else begin
            logic exp_ov;
            exp_ov = !flush && q.size() > 0 && q[0].age >= 1;
            chk("in_ready", 64'(in_ready), 64'(!flush && (q.size() < 2 || out_ready)));
            chk("out_valid", 64'(out_valid), 64'(exp_ov));
            chk("busy", 64'(busy), 64'(q.size() != 0));
            chk("occupancy", 64'(q.size() <= 2), 64'(1));
            if (prev_hold && out_valid) begin
                chk("hold_result", 64'(out_result), 64'(prev_res));
                chk("hold_tag", 64'(out_tag), 64'(prev_tag));
            end
            prev_hold = out_valid && !out_ready;
            prev_res  = out_result;
            prev_tag  = out_tag;
            if (flush) begin
                q.delete();
            end else begin
                foreach (q[i]) q[i].age = q[i].age + 1;
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        chk("spurious_out", 64'(1), 64'(0));
                    end else begin
                        chk("result", 64'(out_result), 64'(q[0].res));
                        chk("tag", 64'(out_tag), 64'(q[0].tag));
                        void'(q.pop_front());
                    end
                end
                if (in_valid && in_ready) begin
                    q.push_back('{res: exp_drv, tag: in_tag, age: 0});
                    n_acc++;
                end
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] tag, input logic [31:0] exp, output int waits);
        logic acc;
        acc = 1'b0;
        waits = 0;
        in_valid = 1'b1; in_op = op; in_src1 = a; in_src2 = b; in_tag = tag; exp_drv = exp;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) break;
            waits++;
        end
        chk("send_accept", 64'(acc), 64'(1));
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && q.size() != 0; k++) begin
            @(posedge clk); #1;
        end
        chk("drain_empty", 64'(q.size()), 64'(0));
        chk("drain_busy", 64'(busy), 64'(0));
    endtask

    initial begin
        int w;
        int idx;
        int n0;
        logic acc;
        logic [31:0] a;
        logic [31:0] b;

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = '0; in_src1 = '0; in_src2 = '0;
        in_tag = '0; out_ready = 1'b1; exp_drv = '0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_result", 64'(out_result), 64'(0));
        chk("rst_tag", 64'(out_tag), 64'(0));
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;

        // Arithmetic corners with fixed expected words
        send(2'b00, 32'h00000003, 32'hFFFFFFFE, 5'd1, 32'hFFFFFFFA, w);
        send(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'h00000000, w);
        send(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 32'hFFFFFFFE, w);
        send(2'b01, 32'h80000000, 32'h80000000, 5'd4, 32'h40000000, w);
        send(2'b01, 32'h80000000, 32'h00000002, 5'd5, 32'hFFFFFFFF, w);
        send(2'b11, 32'hFFFFFFFF, 32'h00000002, 5'd6, 32'hFFFFFFFE, w);
        drain();

        // Streaming: back-to-back MULs must never stall
        for (int i = 0; i < 8; i++) begin
            send(2'b00, 32'(i), 32'(i + 1), TAG_W'(i), 32'(i * (i + 1)), w);
            chk("stream_wait", 64'(w), 64'(0));
        end
        drain();

        // Backpressure: only two ops fit while the output is blocked
        out_ready = 1'b0;
        idx = 0;
        n0 = n_acc;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1; in_op = 2'b00; in_src1 = 32'(idx + 10); in_src2 = 32'd3;
            in_tag = TAG_W'(idx + 20); exp_drv = 32'((idx + 10) * 3);
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) idx++;
        end
        in_valid = 1'b0;
        chk("bp_accepted", 64'(n_acc - n0), 64'(2));
        chk("bp_in_ready", 64'(in_ready), 64'(0));
        chk("bp_out_tag", 64'(out_tag), 64'(20));
        out_ready = 1'b1;
        while (idx < 4) begin
            send(2'b00, 32'(idx + 10), 32'd3, TAG_W'(idx + 20), 32'((idx + 10) * 3), w);
            idx++;
        end
        drain();

        // Flush with two ops in flight and a concurrent input
        out_ready = 1'b0;
        send(2'b10, 32'hDEADBEEF, 32'h12345678, 5'd9, ref_mul(2'b10, 32'hDEADBEEF, 32'h12345678), w);
        send(2'b00, 32'h7, 32'h9, 5'd10, 32'd63, w);
        flush = 1'b1; in_valid = 1'b1; in_op = 2'b00; in_src1 = 32'd5; in_src2 = 32'd5;
        in_tag = 5'd11; exp_drv = 32'd25;
        #1;
        chk("flush_out_valid", 64'(out_valid), 64'(0));
        chk("flush_in_ready", 64'(in_ready), 64'(0));
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_busy", 64'(busy), 64'(0));
        out_ready = 1'b1;
        send(2'b01, 32'hFFFFFFF0, 32'h00000010, 5'd12, 32'hFFFFFFFF, w);
        drain();

        // Asynchronous reset mid-cycle with two ops in flight
        out_ready = 1'b0;
        send(2'b00, 32'd6, 32'd7, 5'd13, 32'd42, w);
        send(2'b00, 32'd8, 32'd9, 5'd14, 32'd72, w);
        #2 reset = 1'b1;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'(0));
        chk("arst_busy", 64'(busy), 64'(0));
        chk("arst_result", 64'(out_result), 64'(0));
        chk("arst_tag", 64'(out_tag), 64'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        out_ready = 1'b1;
        chk("arst_in_ready", 64'(in_ready), 64'(1));
        repeat (3) @(posedge clk);
        #1;
        chk("arst_no_stale", 64'(out_valid), 64'(0));

        // Randomized traffic with backpressure and occasional flushes
        for (int c = 0; c < 600; c++) begin
            case ($urandom_range(3))
                0:       a = 32'hFFFFFFFF;
                1:       a = 32'h80000000;
                default: a = $urandom;
            endcase
            b = ($urandom_range(3) == 0) ? 32'h7FFFFFFF : $urandom;
            in_valid  = ($urandom_range(3) != 0);
            in_op     = 2'($urandom_range(3));
            in_src1   = a;
            in_src2   = b;
            in_tag    = TAG_W'($urandom);
            exp_drv   = ref_mul(in_op, a, b);
            out_ready = ($urandom_range(2) != 0);
            flush     = ($urandom_range(24) == 0);
            @(posedge clk); #1;
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
